// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core
// memory stage and an external master, with a no-ack watchdog.
// Ports: clk, reset (async, active-low)
//   core_*  : memory-stage request, stall, load data, done pulse
//   ext_*   : loader/DMA request, read data, done pulse
//   dmem_*  : registered req/ack port to variable-latency memory
//   bus_err : sticky flag, set when any access times out
module dmem_access_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic        core_stall,
   output logic [31:0] core_rdata,
   output logic        core_done,
   input  logic        ext_req,
   input  logic        ext_we,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   output logic [31:0] ext_rdata,
   output logic        ext_done,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        bus_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_CORE,
      BUSY_EXT,
      RESP
   } state_t;

   state_t        state, state_n;
   logic          last_ext, last_ext_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          req_n, we_n, err_n;
   logic [31:0]   addr_n, wdata_n;
   logic [31:0]   crd_n, erd_n;
   logic          cdone_n, edone_n;
   logic          grant_core, grant_ext;

   // On a tie the requester that did not win last time is served.
   assign grant_core = core_req & (~ext_req | last_ext);
   assign grant_ext  = ext_req & (~core_req | ~last_ext);

   // Pipeline advances in the cycle the done pulse is visible.
   assign core_stall = core_req & ~core_done;

   always_comb begin
      state_n    = state;
      last_ext_n = last_ext;
      cnt_n      = cnt;
      req_n      = dmem_req;
      we_n       = dmem_we;
      addr_n     = dmem_addr;
      wdata_n    = dmem_wdata;
      crd_n      = core_rdata;
      erd_n      = ext_rdata;
      err_n      = bus_err;
      cdone_n    = 1'b0;
      edone_n    = 1'b0;
      unique case (state)
         IDLE: begin
            unique case (1'b1)
               grant_core: begin
                  we_n       = core_we;
                  addr_n     = core_addr;
                  wdata_n    = core_wdata;
                  req_n      = 1'b1;
                  last_ext_n = 1'b0;
                  cnt_n      = '0;
                  state_n    = BUSY_CORE;
               end
               grant_ext: begin
                  we_n       = ext_we;
                  addr_n     = ext_addr;
                  wdata_n    = ext_wdata;
                  req_n      = 1'b1;
                  last_ext_n = 1'b1;
                  cnt_n      = '0;
                  state_n    = BUSY_EXT;
               end
               default: ;
            endcase
         end
         BUSY_CORE, BUSY_EXT: begin
            if (dmem_ack) begin
               req_n   = 1'b0;
               state_n = RESP;
               if (state == BUSY_EXT) begin
                  erd_n   = dmem_rdata;
                  edone_n = 1'b1;
               end else begin
                  crd_n   = dmem_rdata;
                  cdone_n = 1'b1;
               end
            end else if (cnt == CNT_LAST) begin
               // Watchdog: complete with zero data and flag it.
               req_n   = 1'b0;
               err_n   = 1'b1;
               state_n = RESP;
               if (state == BUSY_EXT) begin
                  erd_n   = '0;
                  edone_n = 1'b1;
               end else begin
                  crd_n   = '0;
                  cdone_n = 1'b1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_ext   <= 1'b1;
         cnt        <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         core_rdata <= '0;
         ext_rdata  <= '0;
         core_done  <= 1'b0;
         ext_done   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         state      <= state_n;
         last_ext   <= last_ext_n;
         cnt        <= cnt_n;
         dmem_req   <= req_n;
         dmem_we    <= we_n;
         dmem_addr  <= addr_n;
         dmem_wdata <= wdata_n;
         core_rdata <= crd_n;
         ext_rdata  <= erd_n;
         core_done  <= cdone_n;
         ext_done   <= edone_n;
         bus_err    <= err_n;
      end
   end

endmodule
